// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if: control inputs and scan outputs of the display scan controller
interface display_scan_controller_if;
  logic       enable;
  logic [3:0] digit_mask;
  logic [3:0] brightness;
  logic [1:0] sync_count;
  logic [3:0] anode;
  logic       blank;
  logic       frame_done;
  modport master (
    output enable, digit_mask, brightness,
    input  sync_count, anode, blank, frame_done
  );
  modport slave (
    input  enable, digit_mask, brightness,
    output sync_count, anode, blank, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// display_scan_controller: four-digit scan sequencer with blanking gap, per-digit PWM and digit masking
module display_scan_controller #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input logic clk,
  input logic reset,
  display_scan_controller_if.slave bus
);
  localparam int MAXT = DIGIT_TICKS > BLANK_TICKS ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW = $clog2(MAXT + 1);
  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc, duty_q, duty_d, duty_new;
  logic [1:0] sc_q, sc_d, low_sc, nxt_sc;
  logic [3:0] an_q, an_d, sel_an;
  logic blank_q, fd_q, fd_d;
  logic [31:0] prod;
  assign prod = (32'(bus.brightness) + 32'd1) * 32'(DIGIT_TICKS);
  assign duty_new = CW'(prod >> 4);
  assign cnt_inc = cnt_q + CW'(1);
  assign sel_an = ~(4'b0001 << sc_q);
  // Lowest set mask bit, and next set bit above sc_q wrapping through 0 (sc_q itself if it is the only one)
  always_comb begin
    low_sc = 2'd0;
    nxt_sc = sc_q;
    for (int i = 3; i >= 0; i--) if (bus.digit_mask[i]) low_sc = 2'(i);
    for (int i = 4; i >= 1; i--) if (bus.digit_mask[2'(sc_q + 2'(i))]) nxt_sc = 2'(sc_q + 2'(i));
  end
  // Outputs are computed for the state being entered so they can be registered alongside it
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    sc_d = sc_q;
    duty_d = duty_q;
    an_d = 4'hF;
    fd_d = 1'b0;
    if (!bus.enable || bus.digit_mask == 4'd0) state_d = IDLE;
    else case (state_q)
      IDLE: begin
        state_d = BLANK;
        sc_d = low_sc;
      end
      BLANK: if (cnt_q == CW'(BLANK_TICKS - 1)) begin
        state_d = ON;
        duty_d = duty_new;
        an_d = duty_new != '0 ? sel_an : 4'hF;
      end else cnt_d = cnt_inc;
      ON: if (cnt_q == CW'(DIGIT_TICKS - 1)) begin
        state_d = BLANK;
        sc_d = nxt_sc;
        fd_d = nxt_sc <= sc_q;
      end else begin
        cnt_d = cnt_inc;
        an_d = cnt_inc < duty_q ? sel_an : 4'hF;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      duty_q <= '0;
      sc_q <= 2'd0;
      an_q <= 4'hF;
      blank_q <= 1'b1;
      fd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      duty_q <= duty_d;
      sc_q <= sc_d;
      an_q <= an_d;
      blank_q <= an_d == 4'hF;
      fd_q <= fd_d;
    end
  end
  assign bus.sync_count = sc_q;
  assign bus.anode = an_q;
  assign bus.blank = blank_q;
  assign bus.frame_done = fd_q;
endmodule
